// File: rtl/vstore_bank_sched_pkg.sv
// vstore_bank_sched_pkg: store-size encodings, FSM states and memory geometry defaults
package vstore_bank_sched_pkg;
    localparam logic [1:0] SZ_SB = 2'd0;
    localparam logic [1:0] SZ_SH = 2'd1;
    localparam logic [1:0] SZ_SW = 2'd2;
    localparam int NLANES_DEF = 4;
    localparam int NBANKS_DEF = 4;
    localparam int ADDR_W_DEF = 14;
    localparam int DMEM_BYTES = 2 ** ADDR_W_DEF;
    typedef enum logic {IDLE, ISSUE} state_t;
endpackage

// File: rtl/vstore_bank_sched_if.sv
// vstore_bank_sched_if: store request handshake and multi-bank write bus
interface vstore_bank_sched_if
    import vstore_bank_sched_pkg::*;
#(
    parameter int NLANES  = NLANES_DEF,
    parameter int NBANKS  = NBANKS_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int BANK_AW = ADDR_W - 2 - $clog2(NBANKS)
);
    logic                      req_valid;
    logic                      req_ready;
    logic                      req_vector;
    logic [1:0]                req_size;
    logic [NLANES-1:0]         req_mask;
    logic [NLANES*ADDR_W-1:0]  req_addr;
    logic [NLANES*32-1:0]      req_data;
    logic [NBANKS*4-1:0]       dm_write;
    logic [NBANKS*BANK_AW-1:0] dm_addr;
    logic [NBANKS*32-1:0]      dm_data;
    logic                      busy;
    logic                      done;
    logic                      misalign_err;
    modport master (
        output req_valid, req_vector, req_size, req_mask, req_addr, req_data,
        input  req_ready, dm_write, dm_addr, dm_data, busy, done, misalign_err
    );
    modport slave (
        input  req_valid, req_vector, req_size, req_mask, req_addr, req_data,
        output req_ready, dm_write, dm_addr, dm_data, busy, done, misalign_err
    );
endinterface

// File: rtl/vstore_bank_sched_store_lane_fmt.sv
// store_lane_fmt: per-lane byte strobes, lane-shifted data and misalignment flag
module store_lane_fmt
    import vstore_bank_sched_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic [31:0] data,
    output logic [3:0]  strb,
    output logic [31:0] wdata,
    output logic        misalign
);
    always_comb begin
        misalign = (size == SZ_SH && off[0]) || (size == SZ_SW && off != 2'd0);
        strb = misalign ? 4'b0000 :
               size == SZ_SB ? 4'b1000 >> off :
               size == SZ_SH ? 4'b1100 >> off :
               size == SZ_SW ? 4'b1111 : 4'b0000;
        wdata = size == SZ_SB ? {24'b0, data[7:0]} << {off, 3'b000} :
                size == SZ_SH ? {16'b0, data[15:0]} << {off, 3'b000} : data;
    end
endmodule

// File: rtl/vstore_bank_sched.sv
// vstore_bank_sched: maps store lanes to banks, issuing lowest pending lane per bank each cycle
module vstore_bank_sched
    import vstore_bank_sched_pkg::*;
#(
    parameter int NLANES  = NLANES_DEF,
    parameter int NBANKS  = NBANKS_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int BANK_AW = ADDR_W - 2 - $clog2(NBANKS)
) (
    input logic clk,
    input logic rst,
    vstore_bank_sched_if.slave bus
);
    localparam int BW = $clog2(NBANKS);
    localparam int WW = ADDR_W - 2;
    state_t state;
    logic [NLANES-1:0] pending, pend_in, eff, mis, issued, nxt;
    logic [NLANES-1:0][3:0] strb_in, strb_q;
    logic [NLANES-1:0][31:0] data_in, data_q;
    logic [NLANES-1:0][WW-1:0] word_in, word_q;
    logic [NBANKS-1:0][NLANES-1:0] hit, gnt;
    logic [NBANKS-1:0][3:0] wr;
    logic [NBANKS-1:0][BANK_AW-1:0] ad;
    logic [NBANKS-1:0][31:0] dt;
    logic err_q;
    for (genvar i = 0; i < NLANES; i++) begin : g_lane
        store_lane_fmt u_fmt (
            .size(bus.req_size),
            .off(bus.req_addr[i*ADDR_W +: 2]),
            .data(bus.req_data[i*32 +: 32]),
            .strb(strb_in[i]),
            .wdata(data_in[i]),
            .misalign(mis[i])
        );
        assign eff[i] = bus.req_vector ? bus.req_mask[i] : (i == 0);
        assign word_in[i] = bus.req_addr[i*ADDR_W+2 +: WW];
        // reserved size yields no strobes, so such lanes never become pending
        assign pend_in[i] = eff[i] && !mis[i] && strb_in[i] != 4'b0000;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pending <= '0;
            err_q <= 1'b0;
        end else if (state == IDLE) begin
            err_q <= 1'b0;
            if (bus.req_valid) begin
                state <= ISSUE;
                pending <= pend_in;
                err_q <= |(eff & mis);
            end
        end else begin
            pending <= nxt;
            err_q <= 1'b0;
            if (nxt == '0) state <= IDLE;
        end
    end
    always_ff @(posedge clk) begin
        if (state == IDLE && bus.req_valid) begin
            strb_q <= strb_in;
            data_q <= data_in;
            word_q <= word_in;
        end
    end
    // per bank, isolate the lowest pending lane so same-word stores retire in lane order
    always_comb begin
        hit = '0;
        gnt = '0;
        wr = '0;
        ad = '0;
        dt = '0;
        issued = '0;
        for (int b = 0; b < NBANKS; b++) begin
            for (int l = 0; l < NLANES; l++)
                hit[b][l] = state == ISSUE && pending[l] && word_q[l][BW-1:0] == BW'(b);
            gnt[b] = hit[b] & (~hit[b] + NLANES'(1));
            for (int l = 0; l < NLANES; l++) begin
                if (gnt[b][l]) begin
                    wr[b] = strb_q[l];
                    ad[b] = word_q[l][WW-1:BW];
                    dt[b] = data_q[l];
                    issued[l] = 1'b1;
                end
            end
        end
    end
    assign nxt = pending & ~issued;
    assign bus.req_ready = state == IDLE;
    assign bus.busy = state == ISSUE;
    assign bus.done = state == ISSUE && nxt == '0;
    assign bus.misalign_err = err_q;
    assign bus.dm_write = wr;
    assign bus.dm_addr = ad;
    assign bus.dm_data = dt;
endmodule

// File: tb/tb_vstore_bank_sched.sv
// tb_vstore_bank_sched: directed vector table plus conflict, same-word and reset sequences
module tb_vstore_bank_sched;
    typedef struct {
        logic         vec;
        logic [1:0]   size;
        logic [3:0]   mask;
        logic [55:0]  addr;
        logic [127:0] data;
        logic [15:0]  wr;
        logic [39:0]  ad;
        logic [127:0] dt;
        logic         err;
    } tv_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    tv_t tv [10];
    tv_t hv;
    logic [31:0] da [4];
    logic [31:0] m;
    always #5 clk = ~clk;
    vstore_bank_sched_if #(.NLANES(4), .NBANKS(4), .ADDR_W(14), .BANK_AW(10)) bus ();
    vstore_bank_sched #(.NLANES(4), .NBANKS(4), .ADDR_W(14), .BANK_AW(10)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    task automatic send(input tv_t v, input string nm);
        @(negedge clk);
        chk({nm, "_ready_before"}, 128'(bus.req_ready), 128'(1));
        bus.req_valid = 1'b1;
        bus.req_vector = v.vec;
        bus.req_size = v.size;
        bus.req_mask = v.mask;
        bus.req_addr = v.addr;
        bus.req_data = v.data;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        bus.req_data = '1;
        bus.req_addr = '1;
    endtask
    task automatic bank0_cycle(input string nm, input int k, input logic [31:0] d, input logic dn);
        chk({nm, "_write"}, 128'(bus.dm_write), 128'(16'h000F));
        chk({nm, "_addr"}, 128'(bus.dm_addr), 128'(k));
        chk({nm, "_data"}, 128'(bus.dm_data), 128'(d));
        chk({nm, "_done"}, 128'(bus.done), 128'(dn));
        chk({nm, "_ready"}, 128'(bus.req_ready), 128'(0));
    endtask
    initial begin
        bus.req_valid = 1'b0;
        bus.req_vector = 1'b0;
        bus.req_size = 2'd0;
        bus.req_mask = '0;
        bus.req_addr = '0;
        bus.req_data = '0;
        tv[0] = '{vec:1'b0, size:2'd0, mask:4'b0001, addr:{14'h0, 14'h0, 14'h0, 14'h0007},
                  data:{96'h0, 32'h000000AB}, wr:16'h0010, ad:40'h0,
                  dt:{32'h0, 32'h0, 32'hAB000000, 32'h0}, err:1'b0};
        tv[1] = '{vec:1'b1, size:2'd2, mask:4'b1111, addr:{14'h0C, 14'h08, 14'h04, 14'h00},
                  data:{32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}, wr:16'hFFFF, ad:40'h0,
                  dt:{32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}, err:1'b0};
        tv[2] = '{vec:1'b1, size:2'd2, mask:4'b0011, addr:{14'h0, 14'h0, 14'h01, 14'h00},
                  data:{64'h0, 32'hDEADBEEF, 32'hCAFEF00D}, wr:16'h000F, ad:40'h0,
                  dt:{96'h0, 32'hCAFEF00D}, err:1'b1};
        tv[3] = '{vec:1'b1, size:2'd1, mask:4'b0011, addr:{14'h0, 14'h0, 14'h05, 14'h02},
                  data:{64'h0, 32'hFFFF9999, 32'hAAAA1234}, wr:16'h0003, ad:40'h0,
                  dt:{96'h0, 32'h12340000}, err:1'b1};
        tv[4] = '{vec:1'b0, size:2'd1, mask:4'b0001, addr:{14'h0, 14'h0, 14'h0, 14'h04},
                  data:{96'h0, 32'h5555BEEF}, wr:16'h00C0, ad:40'h0,
                  dt:{64'h0, 32'h0000BEEF, 32'h0}, err:1'b0};
        tv[5] = '{vec:1'b1, size:2'd2, mask:4'b0000, addr:{14'h0C, 14'h08, 14'h04, 14'h00},
                  data:{128{1'b1}}, wr:16'h0, ad:40'h0, dt:128'h0, err:1'b0};
        tv[6] = '{vec:1'b1, size:2'd3, mask:4'b1111, addr:{14'h0C, 14'h08, 14'h04, 14'h00},
                  data:{128{1'b1}}, wr:16'h0, ad:40'h0, dt:128'h0, err:1'b0};
        tv[7] = '{vec:1'b0, size:2'd2, mask:4'b1111, addr:{14'h00, 14'h04, 14'h08, 14'h0C},
                  data:{32'h33333333, 32'h22222222, 32'h11111111, 32'h0BADCAFE}, wr:16'hF000, ad:40'h0,
                  dt:{32'h0BADCAFE, 96'h0}, err:1'b0};
        tv[8] = '{vec:1'b1, size:2'd0, mask:4'b1100, addr:{14'h3FFC, 14'h0012, 14'h0, 14'h0},
                  data:{32'hABCDEF77, 32'h1234565A, 64'hFFFFFFFFFFFFFFFF}, wr:16'h8002,
                  ad:{10'h3FF, 10'h0, 10'h0, 10'h001}, dt:{32'h00000077, 64'h0, 32'h005A0000}, err:1'b0};
        tv[9] = '{vec:1'b1, size:2'd2, mask:4'b0011, addr:{14'h0, 14'h0, 14'h06, 14'h02},
                  data:{128{1'b1}}, wr:16'h0, ad:40'h0, dt:128'h0, err:1'b1};
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 128'(bus.req_ready), 128'(1));
        chk("rst_busy", 128'(bus.busy), 128'(0));
        chk("rst_done", 128'(bus.done), 128'(0));
        chk("rst_err", 128'(bus.misalign_err), 128'(0));
        chk("rst_write", 128'(bus.dm_write), 128'(0));
        chk("rst_addr", 128'(bus.dm_addr), 128'(0));
        chk("rst_data", 128'(bus.dm_data), 128'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        for (int n = 0; n < 10; n++) begin
            send(tv[n], $sformatf("v%0d", n));
            @(negedge clk);
            chk($sformatf("v%0d_write", n), 128'(bus.dm_write), 128'(tv[n].wr));
            chk($sformatf("v%0d_addr", n), 128'(bus.dm_addr), 128'(tv[n].ad));
            chk($sformatf("v%0d_data", n), bus.dm_data, tv[n].dt);
            chk($sformatf("v%0d_done", n), 128'(bus.done), 128'(1));
            chk($sformatf("v%0d_err", n), 128'(bus.misalign_err), 128'(tv[n].err));
            chk($sformatf("v%0d_busy", n), 128'(bus.busy), 128'(1));
            chk($sformatf("v%0d_ready", n), 128'(bus.req_ready), 128'(0));
            @(negedge clk);
            chk($sformatf("v%0d_after_done", n), 128'(bus.done), 128'(0));
            chk($sformatf("v%0d_after_write", n), 128'(bus.dm_write), 128'(0));
            chk($sformatf("v%0d_after_busy", n), 128'(bus.busy), 128'(0));
            chk($sformatf("v%0d_after_err", n), 128'(bus.misalign_err), 128'(0));
        end
        // all four lanes in bank 0: one write per cycle in lane order
        da = '{32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3};
        hv = '{vec:1'b1, size:2'd2, mask:4'b1111, addr:{14'h30, 14'h20, 14'h10, 14'h00},
               data:{da[3], da[2], da[1], da[0]}, wr:16'h0, ad:40'h0, dt:128'h0, err:1'b0};
        send(hv, "conf");
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bank0_cycle($sformatf("conf_c%0d", k), k, da[k], k == 3);
        end
        @(negedge clk);
        chk("conf_end_ready", 128'(bus.req_ready), 128'(1));
        chk("conf_end_done", 128'(bus.done), 128'(0));
        // lanes 0 and 2 on the same word: lane 2 must land last
        hv = '{vec:1'b1, size:2'd2, mask:4'b0101, addr:{14'h0, 14'h40, 14'h0, 14'h40},
               data:{32'h0, 32'h22222222, 32'h0, 32'h11111111}, wr:16'h0, ad:40'h0, dt:128'h0, err:1'b0};
        m = 32'h0;
        send(hv, "same");
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            bank0_cycle($sformatf("same_c%0d", k), 4, k == 0 ? 32'h11111111 : 32'h22222222, k == 1);
            for (int s = 0; s < 4; s++)
                if (bus.dm_write[s] && bus.dm_addr[9:0] == 10'd4) m[8*(3-s) +: 8] = bus.dm_data[8*(3-s) +: 8];
        end
        chk("same_final_word", 128'(m), 128'(32'h22222222));
        // reset during the second issue cycle of the conflict case
        hv = '{vec:1'b1, size:2'd2, mask:4'b1111, addr:{14'h30, 14'h20, 14'h10, 14'h00},
               data:{da[3], da[2], da[1], da[0]}, wr:16'h0, ad:40'h0, dt:128'h0, err:1'b0};
        send(hv, "rstc");
        @(negedge clk);
        bank0_cycle("rstc_c0", 0, da[0], 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        bank0_cycle("rstc_c1", 1, da[1], 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("rstc_post%0d_write", k), 128'(bus.dm_write), 128'(0));
            chk($sformatf("rstc_post%0d_done", k), 128'(bus.done), 128'(0));
            chk($sformatf("rstc_post%0d_busy", k), 128'(bus.busy), 128'(0));
            chk($sformatf("rstc_post%0d_ready", k), 128'(bus.req_ready), 128'(1));
        end
        send(tv[0], "recov");
        @(negedge clk);
        chk("recov_write", 128'(bus.dm_write), 128'(tv[0].wr));
        chk("recov_data", bus.dm_data, tv[0].dt);
        chk("recov_done", 128'(bus.done), 128'(1));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
